// File: rtl/alu_seq32.sv
// alu_seq32: 32-bit add/subtract unit that reuses a single 8-bit adder over
// four consecutive cycles, least-significant slice first. Result and flags
// are published together when the last slice completes, with a one-cycle
// done pulse.
module alu_seq32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        cf,
  output logic        of,
  output logic        sf,
  output logic        zf,
  output logic        pf
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        sub_q, sub_d;
  logic [31:0] shadow_q, shadow_d;
  logic        carry_q, carry_d;
  logic        done_q, done_d;
  logic [31:0] result_q, result_d;
  logic        cf_q, cf_d;
  logic        of_q, of_d;
  logic        sf_q, sf_d;
  logic        zf_q, zf_d;
  logic        pf_q, pf_d;

  // Slice datapath signals
  logic [7:0]  a_sl;
  logic [7:0]  b_sl;
  logic        cin_sl;
  logic [8:0]  sum_sl;
  logic        c_into_msb;
  logic [31:0] full_res;

  // 8-bit add with carry-in; bit 8 of the return value is the carry-out.
  function automatic logic [8:0] slice_add(input logic [7:0] x,
                                           input logic [7:0] y,
                                           input logic       ci);
    slice_add = {1'b0, x} + {1'b0, y} + {8'b0, ci};
  endfunction

  // Even parity detect: 1 when the byte has an even number of ones.
  function automatic logic even_parity(input logic [7:0] x);
    even_parity = ~(^x);
  endfunction

  // Select the active slice and run it through the shared 8-bit adder.
  always_comb begin
    a_sl       = a_q[{cnt_q, 3'b000} +: 8];
    b_sl       = b_q[{cnt_q, 3'b000} +: 8] ^ {8{sub_q}};
    cin_sl     = (cnt_q == 2'd0) ? sub_q : carry_q;
    sum_sl     = slice_add(a_sl, b_sl, cin_sl);
    // Carry into the top bit of the slice, needed for signed overflow on slice 3.
    c_into_msb = a_sl[7] ^ b_sl[7] ^ sum_sl[7];
    full_res   = {sum_sl[7:0], shadow_q[23:0]};
  end

  // Next-state logic: operand capture, slice sequencing and completion update.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    sub_d    = sub_q;
    shadow_d = shadow_q;
    carry_d  = carry_q;
    done_d   = 1'b0;
    result_d = result_q;
    cf_d     = cf_q;
    of_d     = of_q;
    sf_d     = sf_q;
    zf_d     = zf_q;
    pf_d     = pf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = 2'd0;
          a_d     = a;
          b_d     = b;
          sub_d   = sub;
        end
      end
      RUN: begin
        carry_d = sum_sl[8];
        case (cnt_q)
          2'd0:    shadow_d[7:0]   = sum_sl[7:0];
          2'd1:    shadow_d[15:8]  = sum_sl[7:0];
          2'd2:    shadow_d[23:16] = sum_sl[7:0];
          default: shadow_d[31:24] = sum_sl[7:0];
        endcase
        if (cnt_q == 2'd3) begin
          // Last slice: publish result and flags; counter returns to 0 only here.
          state_d  = IDLE;
          cnt_d    = 2'd0;
          done_d   = 1'b1;
          result_d = full_res;
          cf_d     = sum_sl[8] ^ sub_q;
          of_d     = c_into_msb ^ sum_sl[8];
          sf_d     = full_res[31];
          zf_d     = (full_res == 32'd0);
          pf_d     = even_parity(full_res[7:0]);
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous active-low reset clearing everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 2'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      sub_q    <= 1'b0;
      shadow_q <= 32'd0;
      carry_q  <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 32'd0;
      cf_q     <= 1'b0;
      of_q     <= 1'b0;
      sf_q     <= 1'b0;
      zf_q     <= 1'b0;
      pf_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sub_q    <= sub_d;
      shadow_q <= shadow_d;
      carry_q  <= carry_d;
      done_q   <= done_d;
      result_q <= result_d;
      cf_q     <= cf_d;
      of_q     <= of_d;
      sf_q     <= sf_d;
      zf_q     <= zf_d;
      pf_q     <= pf_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = done_q;
  assign result = result_q;
  assign cf     = cf_q;
  assign of     = of_q;
  assign sf     = sf_q;
  assign zf     = zf_q;
  assign pf     = pf_q;

endmodule
